// File: rtl/mult_12x12_if.sv
// ---------------------------------------------------------------------------
// mult_12x12_if
// Operand/result bundle for the pipelined signed 12x12 Booth multiplier.
//
// Signals:
//   In_Valid        Din/Coeff are valid this cycle        (master -> slave)
//   Din      [11:0] signed two's-complement sample         (master -> slave)
//   Coeff    [11:0] signed two's-complement coefficient    (master -> slave)
//   Product  [23:0] signed full-precision Din*Coeff        (slave -> master)
//   Out_Valid       Product belongs to a valid input pair  (slave -> master)
//   Product_Scaled [11:0]  Product[22:11], Q11 rescale     (slave -> master)
//                   only present when MULT_12X12_SCALED_OUT_EN is defined
//
// Modports: master drives operands, slave (the multiplier) drives results.
// ---------------------------------------------------------------------------
interface mult_12x12_if;

    logic        In_Valid;
    logic [11:0] Din;
    logic [11:0] Coeff;
    logic [23:0] Product;
    logic        Out_Valid;
`ifdef MULT_12X12_SCALED_OUT_EN
    logic [11:0] Product_Scaled;

    modport master (output In_Valid, Din, Coeff,
                    input  Product, Out_Valid, Product_Scaled);
    modport slave  (input  In_Valid, Din, Coeff,
                    output Product, Out_Valid, Product_Scaled);
`else
    modport master (output In_Valid, Din, Coeff,
                    input  Product, Out_Valid);
    modport slave  (input  In_Valid, Din, Coeff,
                    output Product, Out_Valid);
`endif

endinterface

// File: rtl/mult_12x12.sv
// ---------------------------------------------------------------------------
// mult_12x12
// Pipelined signed 12x12 multiplier built from radix-4 Booth partial products
// and a registered adder tree (no inferred DSP multiply). Used as the per-tap
// multiplier of the transposed-form FIR filter.
//
// Parameters:
//   LATENCY  cycles from sampled input pair to Product/Out_Valid (1 or 2).
//            2 registers the two half-tree sums and the output,
//            1 registers only the output.
//
// Ports:
//   Clk   rising-edge clock
//   Hlt   synchronous active-high reset; clears every pipeline register
//   bus   mult_12x12_if.slave: In_Valid/Din/Coeff in, Product/Out_Valid out
//
// Optional feature macro: MULT_12X12_SCALED_OUT_EN
//   adds bus.Product_Scaled = Product[22:11], registered with Product.
// ---------------------------------------------------------------------------
module mult_12x12 #(
    parameter int LATENCY = 2
) (
    input  logic        Clk,
    input  logic        Hlt,
    mult_12x12_if.slave bus
);

    logic [23:0] w_dinExt;
    logic [12:0] w_coeffExt;
    logic [23:0] w_pp [6];
    logic [23:0] w_sumLo;
    logic [23:0] w_sumHi;
    logic [23:0] w_final;
    logic        w_finalValid;

    logic [23:0] r_product;
    logic        r_outValid;

    // Booth recoding: the coefficient gets an implicit 0 below its LSB and is
    // scanned in overlapping 3-bit windows. Each window picks 0, +-Din or
    // +-2Din, weighted by 4^i. All arithmetic is modulo 2^24, which is exact
    // because every true product fits in 24 bits signed.
    always_comb begin
        w_dinExt   = {{12{bus.Din[11]}}, bus.Din};
        w_coeffExt = {bus.Coeff, 1'b0};
        for (int i = 0; i < 6; i++) begin
            w_pp[i] = '0;
            case (w_coeffExt[2*i +: 3])
                3'b001, 3'b010: w_pp[i] = w_dinExt;
                3'b011:         w_pp[i] = w_dinExt << 1;
                3'b100:         w_pp[i] = -(w_dinExt << 1);
                3'b101, 3'b110: w_pp[i] = -w_dinExt;
                default:        w_pp[i] = '0;
            endcase
            w_pp[i] = w_pp[i] << (2 * i);
        end
    end

    // Two half trees so the LATENCY=2 build can register them separately.
    assign w_sumLo = w_pp[0] + w_pp[1] + w_pp[2];
    assign w_sumHi = w_pp[3] + w_pp[4] + w_pp[5];

    generate
        if (LATENCY == 2) begin : g_lat2
            logic [23:0] r_sumLo;
            logic [23:0] r_sumHi;
            logic        r_validS1;

            // First pipeline stage: hold the half-tree sums and the valid bit.
            always_ff @(posedge Clk) begin
                if (Hlt) begin
                    r_sumLo   <= '0;
                    r_sumHi   <= '0;
                    r_validS1 <= 1'b0;
                end else begin
                    r_sumLo   <= w_sumLo;
                    r_sumHi   <= w_sumHi;
                    r_validS1 <= bus.In_Valid;
                end
            end

            assign w_final      = r_sumLo + r_sumHi;
            assign w_finalValid = r_validS1;
        end else if (LATENCY == 1) begin : g_lat1
            assign w_final      = w_sumLo + w_sumHi;
            assign w_finalValid = bus.In_Valid;
        end else begin : g_badLatency
            $error("mult_12x12: LATENCY must be 1 or 2");
        end
    endgenerate

`ifdef MULT_12X12_SCALED_OUT_EN
    logic [11:0] r_productScaled;

    // Output stage including the Q11 rescale, which shares Product's timing.
    always_ff @(posedge Clk) begin
        if (Hlt) begin
            r_product       <= '0;
            r_outValid      <= 1'b0;
            r_productScaled <= '0;
        end else begin
            r_product       <= w_final;
            r_outValid      <= w_finalValid;
            r_productScaled <= w_final[22:11];
        end
    end

    assign bus.Product_Scaled = r_productScaled;
`else
    // Output stage: the final add lands here; invalid pairs still flow through.
    always_ff @(posedge Clk) begin
        if (Hlt) begin
            r_product  <= '0;
            r_outValid <= 1'b0;
        end else begin
            r_product  <= w_final;
            r_outValid <= w_finalValid;
        end
    end
`endif

    assign bus.Product   = r_product;
    assign bus.Out_Valid = r_outValid;

endmodule

// File: tb/tb_mult_12x12.sv
// ---------------------------------------------------------------------------
// tb_mult_12x12
// Directed bench for mult_12x12. Two instances share clock, halt and operands:
// dut2 uses LATENCY=2, dut1 uses LATENCY=1, so every sequence exercises both
// pipeline depths. Expected products are hand-computed constants, plus a
// small signed reference model for a random stream.
// Honours MULT_12X12_SCALED_OUT_EN for the Product_Scaled output.
// ---------------------------------------------------------------------------
module tb_mult_12x12;

    typedef struct {
        string       name;
        int          din;
        int          coeff;
        logic [23:0] expected;
    } vector_t;

    logic clock;
    logic halt;
    int   errorCount;
    int   checkCount;

    vector_t     vectors [12];
    logic [23:0] randExp [200];

    mult_12x12_if bus2 ();
    mult_12x12_if bus1 ();

    mult_12x12 #(.LATENCY(2)) dut2 (
        .Clk (clock),
        .Hlt (halt),
        .bus (bus2)
    );

    mult_12x12 #(.LATENCY(1)) dut1 (
        .Clk (clock),
        .Hlt (halt),
        .bus (bus1)
    );

    // Free-running 10-unit clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive one operand pair into both instances, then step one edge and wait
    // a little so outputs are sampled away from the edge.
    task automatic applyStimulus(input logic valid, input int din, input int coeff);
        bus2.In_Valid = valid;
        bus2.Din      = 12'(din);
        bus2.Coeff    = 12'(coeff);
        bus1.In_Valid = valid;
        bus1.Din      = 12'(din);
        bus1.Coeff    = 12'(coeff);
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [23:0] actual,
                               input logic [23:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Independent signed reference for the random stream.
    function automatic logic [23:0] refProduct(input int din, input int coeff);
        logic signed [11:0] a;
        logic signed [11:0] b;
        int                 p;
        a = 12'(din);
        b = 12'(coeff);
        p = int'(a) * int'(b);
        return 24'(p);
    endfunction

    // Main test sequence.
    initial begin
        int ra;
        int rb;

        errorCount = 0;
        checkCount = 0;

        vectors[0]  = '{"p5_m3",       5,     -3,    24'hFFFFF1};
        vectors[1]  = '{"m2048_m2048", -2048, -2048, 24'h400000};
        vectors[2]  = '{"m2048_p2047", -2048, 2047,  24'hC00800};
        vectors[3]  = '{"zero_m3",     0,     -3,    24'h000000};
        vectors[4]  = '{"p1_p173",     1,     173,   24'h0000AD};
        vectors[5]  = '{"p2047_p173",  2047,  173,   24'h056753};
        vectors[6]  = '{"m1_m1",       -1,    -1,    24'h000001};
        vectors[7]  = '{"p100_zero",   100,   0,     24'h000000};
        vectors[8]  = '{"p2047_p2047", 2047,  2047,  24'h3FF001};
        vectors[9]  = '{"m1_p2047",    -1,    2047,  24'hFFF801};
        vectors[10] = '{"p123_m456",   123,   -456,  24'hFF24E8};
        vectors[11] = '{"m1000_m1000", -1000, -1000, 24'h0F4240};

        // Reset held for three cycles with random valid operands.
        halt = 1'b1;
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b1, int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)));
            checkOutput("rst_prod_l2",  bus2.Product, 24'h000000);
            checkOutput("rst_valid_l2", {23'd0, bus2.Out_Valid}, 24'd0);
            checkOutput("rst_prod_l1",  bus1.Product, 24'h000000);
            checkOutput("rst_valid_l1", {23'd0, bus1.Out_Valid}, 24'd0);
        end
        halt = 1'b0;

        // First pair after reset.
        applyStimulus(1'b1, 5, -3);
        checkOutput("post_rst_prod_l1",  bus1.Product, 24'hFFFFF1);
        checkOutput("post_rst_valid_l1", {23'd0, bus1.Out_Valid}, 24'd1);
        checkOutput("post_rst_valid_l2", {23'd0, bus2.Out_Valid}, 24'd0);
        applyStimulus(1'b0, 0, 0);
        checkOutput("post_rst_prod_l2",  bus2.Product, 24'hFFFFF1);
        checkOutput("post_rst_valid_l2", {23'd0, bus2.Out_Valid}, 24'd1);
        checkOutput("post_rst_valid_l1", {23'd0, bus1.Out_Valid}, 24'd0);
        applyStimulus(1'b0, 0, 0);

        // Table streamed back-to-back; dut2 trails dut1 by one cycle.
        for (int k = 0; k < 12; k++) begin
            applyStimulus(1'b1, vectors[k].din, vectors[k].coeff);
            checkOutput({vectors[k].name, "_l1"}, bus1.Product, vectors[k].expected);
            checkOutput({vectors[k].name, "_v1"}, {23'd0, bus1.Out_Valid}, 24'd1);
`ifdef MULT_12X12_SCALED_OUT_EN
            checkOutput({vectors[k].name, "_s1"}, {12'd0, bus1.Product_Scaled},
                        {12'd0, vectors[k].expected[22:11]});
`endif
            if (k > 0) begin
                checkOutput({vectors[k-1].name, "_l2"}, bus2.Product, vectors[k-1].expected);
                checkOutput({vectors[k-1].name, "_v2"}, {23'd0, bus2.Out_Valid}, 24'd1);
            end
        end
        applyStimulus(1'b0, 0, 0);
        checkOutput({vectors[11].name, "_l2"}, bus2.Product, vectors[11].expected);
        checkOutput("tail_v2", {23'd0, bus2.Out_Valid}, 24'd1);
        checkOutput("tail_v1", {23'd0, bus1.Out_Valid}, 24'd0);

`ifdef MULT_12X12_SCALED_OUT_EN
        // Q11 rescale of 2047*173 (354131 >> 11 = 172).
        applyStimulus(1'b1, 2047, 173);
        checkOutput("scaled_l1", {12'd0, bus1.Product_Scaled}, 24'h0000AC);
        applyStimulus(1'b0, 0, 0);
        checkOutput("scaled_l2", {12'd0, bus2.Product_Scaled}, 24'h0000AC);
`endif
        applyStimulus(1'b0, 0, 0);

        // Valid gap pattern 1,0,1 then idle.
        applyStimulus(1'b1, 3, 4);
        checkOutput("gap0_v1", {23'd0, bus1.Out_Valid}, 24'd1);
        checkOutput("gap0_v2", {23'd0, bus2.Out_Valid}, 24'd0);
        applyStimulus(1'b0, 7, 7);
        checkOutput("gap1_v1", {23'd0, bus1.Out_Valid}, 24'd0);
        checkOutput("gap1_v2", {23'd0, bus2.Out_Valid}, 24'd1);
        checkOutput("gap1_p2", bus2.Product, 24'h00000C);
        applyStimulus(1'b1, -6, 9);
        checkOutput("gap2_v1", {23'd0, bus1.Out_Valid}, 24'd1);
        checkOutput("gap2_p1", bus1.Product, 24'hFFFFCA);
        checkOutput("gap2_v2", {23'd0, bus2.Out_Valid}, 24'd0);
        applyStimulus(1'b0, 0, 0);
        checkOutput("gap3_v1", {23'd0, bus1.Out_Valid}, 24'd0);
        checkOutput("gap3_v2", {23'd0, bus2.Out_Valid}, 24'd1);
        checkOutput("gap3_p2", bus2.Product, 24'hFFFFCA);
        applyStimulus(1'b0, 0, 0);
        checkOutput("gap4_v2", {23'd0, bus2.Out_Valid}, 24'd0);

        // Mid-stream reset: first pair in flight, second pair presented on the
        // halt edge. Both must vanish.
        applyStimulus(1'b1, 11, 13);
        halt = 1'b1;
        applyStimulus(1'b1, 17, 19);
        checkOutput("midrst_p2", bus2.Product, 24'h000000);
        checkOutput("midrst_v2", {23'd0, bus2.Out_Valid}, 24'd0);
        checkOutput("midrst_p1", bus1.Product, 24'h000000);
        checkOutput("midrst_v1", {23'd0, bus1.Out_Valid}, 24'd0);
        halt = 1'b0;
        applyStimulus(1'b0, 0, 0);
        checkOutput("midrst_idle_v2", {23'd0, bus2.Out_Valid}, 24'd0);
        checkOutput("midrst_idle_p2", bus2.Product, 24'h000000);
        applyStimulus(1'b1, -25, 40);
        checkOutput("midrst_next_p1", bus1.Product, 24'hFFFC18);
        checkOutput("midrst_next_v1", {23'd0, bus1.Out_Valid}, 24'd1);
        checkOutput("midrst_next_v2", {23'd0, bus2.Out_Valid}, 24'd0);
        applyStimulus(1'b0, 0, 0);
        checkOutput("midrst_next_p2", bus2.Product, 24'hFFFC18);
        checkOutput("midrst_next_v2b", {23'd0, bus2.Out_Valid}, 24'd1);

        // Random stream against the signed reference model.
        for (int r = 0; r < 200; r++) begin
            ra = int'($urandom_range(0, 4095));
            rb = int'($urandom_range(0, 4095));
            randExp[r] = refProduct(ra, rb);
            applyStimulus(1'b1, ra, rb);
            checkOutput("rand_l1", bus1.Product, randExp[r]);
            if (r > 0) begin
                checkOutput("rand_l2", bus2.Product, randExp[r-1]);
            end
        end
        applyStimulus(1'b0, 0, 0);
        checkOutput("rand_l2_last", bus2.Product, randExp[199]);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/mult_12x12.md
Name: mult_12x12

Overview:
- Pipelined signed 12x12 multiplier producing a full-precision 24-bit two's-complement product.
- Used as the per-tap multiplier in the transposed-form FIR filter: Din = registered sample, Coeff = tap coefficient.
- Internally it uses radix-4 Booth partial products and a registered adder tree. Inferred DSP multiply primitives are not used.

Parameters:
- LATENCY, default 2: cycles from input sample to Product/Out_Valid. Legal values are 1 and 2.
  - 2: registers both the partial-product sums and the output.
  - 1: output register only.

Ports:
- Clk  input  1  rising-edge clock
- Hlt  input  1  synchronous active-high reset (halt)
- In_Valid  input  1  Din/Coeff are valid this cycle
- Din  input  12  signed two's-complement sample
- Coeff  input  12  signed two's-complement coefficient
- Product  output  24  signed product Din*Coeff
- Out_Valid  output  1  Product corresponds to a valid input pair

Behaviour:
- Reset and sampling:
  - All state is updated only on posedge Clk.
  - Hlt high at a clock edge clears every pipeline register: Product=24'h000000, Out_Valid=0. This takes priority over In_Valid.
- Arithmetic:
  - Product = signed(Din) * signed(Coeff), exact.
  - No truncation, rounding or saturation. The range [-4192256, 4194304] fits in 24 bits signed.
  - The corner case -2048 * -2048 = +4194304 (24'h400000) is exact.
- Datapath:
  - Radix-4 Booth recoding of Coeff gives 6 partial products of Din (0, ±Din, ±2Din), sign-extended to 24 bits.
  - The partial products are summed in a tree.
  - With LATENCY=2, the tree is split into two registered halves (PP0-2 and PP3-5), and the final add feeds the output register.
- Latency and throughput:
  - A pair sampled with In_Valid=1 at edge N appears on Product with Out_Valid=1 after edge N+LATENCY.
  - Fully pipelined: one new pair is accepted per cycle. There is no backpressure and no stall.
- Valid handling:
  - In_Valid=0 inputs still propagate through the datapath; Product is don't-care-but-deterministic.
  - Out_Valid is the In_Valid shift chain delayed by LATENCY cycles.
- Reset mid-operation: in-flight results are discarded. Out_Valid stays 0 until LATENCY cycles after the first post-reset valid input.
- Inputs are not checked for X; X on an input propagates to Product.

Optional Feature:
- Macro: MULT_12X12_SCALED_OUT_EN
- When defined:
  - An extra output port Product_Scaled [11:0] is present, equal to Product[22:11] (the FIR's Q11 rescale).
  - It is registered alongside Product with the same latency and is reset to 0.
- When undefined: the port and its logic are absent, and all other behaviour is unchanged.

Test Plan:
- Reset: hold Hlt=1 for 3 cycles with random inputs -> Product=24'h000000, Out_Valid=0 every cycle. Release, drive Din=5, Coeff=-3, In_Valid=1 -> after 2 cycles Product=24'hFFFFF1, Out_Valid=1.
- Corners:
  - Din=-2048, Coeff=-2048 -> 24'h400000.
  - Din=-2048, Coeff=2047 -> 24'hC00800.
  - Din=0, Coeff=-3 -> 24'h000000.
- Pipeline streaming: back-to-back pairs (1,173), (2047,173), (-1,-1), (100,0) -> outputs on consecutive cycles 173, 24'h056753, 1, 0, with Out_Valid high for 4 cycles.
- Valid gaps: pattern In_Valid=1,0,1 -> Out_Valid=1,0,1 delayed by exactly LATENCY. Repeat with LATENCY=1 -> 1-cycle delay.
- Mid-stream reset: assert Hlt for 1 cycle while 2 results are in flight -> both dropped, Product=0 next cycle, and the next valid input returns correctly.
- Scaled output (MULT_12X12_SCALED_OUT_EN): Din=2047, Coeff=173 -> Product_Scaled=12'h0AC. Also sweep 10k random pairs against a signed reference model.
